datapath_unit: RTL

- Execution datapath that sits directly downstream of the control unit and consumes its decoded control signals each cycle.
- Contains a 16x16 register file with two read ports and one write port, an 8-operation 16-bit ALU, a 256x16 data memory with synchronous read, a write-back source mux and a status-flag register.
- Executes the control unit's ADD/SUB/LOAD/STORE/NOOP/HALT sequences, with no handshake back to the control unit.

---
 rtl/datapath_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/datapath_unit.sv
// Execution datapath: 16x16 regfile, 8-op ALU, 256x16 sync-read memory, flags.
// Optional same-cycle write-back bypass on read ports: `define DATAPATH_BYPASS_EN.
//
// Ports:
//   Clk, Reset          clock, async active-high reset
//   D_Addr, D_Wr        data memory address / write enable (store data = Ra_Data)
//   RF_s                write-back select: 0 ALU_Out, 1 Mem_Q
//   RF_W_Addr, RF_W_en  register file write port
//   RF_Ra_Addr/Rb_Addr  register file read ports
//   ALU_s0              ALU operation select
//   Ra_Data, Rb_Data    read port data
//   ALU_Out             combinational ALU result
//   Mem_Q               registered memory read data
//   Flags               {Z, N, C, V}
module datapath_unit #(
  parameter int DW       = 16,
  parameter int RF_DEPTH = 16,
  parameter int DM_DEPTH = 256
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [$clog2(DM_DEPTH)-1:0] D_Addr,
  input  logic                        D_Wr,
  input  logic                        RF_s,
  input  logic [$clog2(RF_DEPTH)-1:0] RF_W_Addr,
  input  logic                        RF_W_en,
  input  logic [$clog2(RF_DEPTH)-1:0] RF_Ra_Addr,
  input  logic [$clog2(RF_DEPTH)-1:0] RF_Rb_Addr,
  input  logic [2:0]                  ALU_s0,
  output logic [DW-1:0]               Ra_Data,
  output logic [DW-1:0]               Rb_Data,
  output logic [DW-1:0]               ALU_Out,
  output logic [DW-1:0]               Mem_Q,
  output logic [3:0]                  Flags
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_INC  = 3'b111;

  localparam int MSB = DW - 1;

  logic [DW-1:0] rf [RF_DEPTH];
  logic [DW-1:0] dm [DM_DEPTH];

  logic [DW-1:0] ra_raw;
  logic [DW-1:0] rb_raw;
  logic [DW-1:0] alu_y;
  logic [DW:0]   sum_ext;
  logic          c_out;
  logic          v_out;
  logic [DW-1:0] wb_data;

  assign ra_raw = rf[RF_Ra_Addr];
  assign rb_raw = rf[RF_Rb_Addr];

  // ALU always works on stored register values so a bypassed
  // read port can never loop back through the adder.
  always_comb begin
    sum_ext = '0;
    alu_y   = '0;
    c_out   = 1'b0;
    v_out   = 1'b0;
    unique case (ALU_s0)
      OP_PASS: alu_y = ra_raw;
      OP_ADD: begin
        sum_ext = {1'b0, ra_raw} + {1'b0, rb_raw};
        alu_y   = sum_ext[DW-1:0];
        c_out   = sum_ext[DW];
        v_out   = (ra_raw[MSB] == rb_raw[MSB])
               && (alu_y[MSB] != ra_raw[MSB]);
      end
      OP_SUB: begin
        // top bit of the extended difference is the borrow (A < B)
        sum_ext = {1'b0, ra_raw} - {1'b0, rb_raw};
        alu_y   = sum_ext[DW-1:0];
        c_out   = sum_ext[DW];
        v_out   = (ra_raw[MSB] != rb_raw[MSB])
               && (alu_y[MSB] != ra_raw[MSB]);
      end
      OP_OR:  alu_y = ra_raw | rb_raw;
      OP_XOR: alu_y = ra_raw ^ rb_raw;
      OP_AND: alu_y = ra_raw & rb_raw;
      OP_NOT: alu_y = ~ra_raw;
      OP_INC: begin
        sum_ext = {1'b0, ra_raw} + {{DW{1'b0}}, 1'b1};
        alu_y   = sum_ext[DW-1:0];
        c_out   = sum_ext[DW];
        v_out   = ~ra_raw[MSB] & alu_y[MSB];
      end
      default: alu_y = '0;
    endcase
  end

  assign ALU_Out = alu_y;
  assign wb_data = RF_s ? Mem_Q : alu_y;

`ifdef DATAPATH_BYPASS_EN
  assign Ra_Data = (RF_W_en && (RF_Ra_Addr == RF_W_Addr))
                 ? wb_data : ra_raw;
  assign Rb_Data = (RF_W_en && (RF_Rb_Addr == RF_W_Addr))
                 ? wb_data : rb_raw;
`else
  assign Ra_Data = ra_raw;
  assign Rb_Data = rb_raw;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else if (RF_W_en) begin
      rf[RF_W_Addr] <= wb_data;
    end
  end

  // Flags only follow ALU write-backs; loads leave them alone.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Flags <= 4'b0000;
    end else if (RF_W_en && !RF_s) begin
      Flags <= {(alu_y == '0), alu_y[MSB], c_out, v_out};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Mem_Q <= '0;
    end else begin
      Mem_Q <= dm[D_Addr];
    end
  end

  // Memory contents survive reset; a store under reset is dropped.
  always_ff @(posedge Clk) begin
    if (D_Wr && !Reset) begin
      dm[D_Addr] <= Ra_Data;
    end
  end

endmodule
